display_scheduler: RTL



---
 rtl/display_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/display_scheduler.sv
// display_scheduler: round-robin time-sharing of the four-digit seven-segment
// display between NUM_REQ requesters. The winner's value and point mask are
// snapshotted at the grant edge and held for a fixed dwell.
//
// Handshake: reqs[i] is a level "valid" held by requester i for as long as it
// wants the display; grant[i] is the registered acknowledge. Dropping reqs[i]
// while granted aborts the dwell. done[i] pulses for one cycle only when a
// full dwell completed with reqs[i] still high on its terminal cycle.
module display_scheduler #(
  parameter int          NUM_REQ      = 4,
  parameter int          DWELL_CYCLES = 50000000,
  parameter int          COUNT_WIDTH  = 26,
  parameter logic [15:0] IDLE_DATA    = 16'h0000
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic [NUM_REQ-1:0]      reqs,
  input  logic [16*NUM_REQ-1:0]   reqData,
  input  logic [4*NUM_REQ-1:0]    reqPoints,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic [15:0]             data,
  output logic [3:0]              pointEnable,
  output logic                    busy,
  output logic                    dbg_state
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [COUNT_WIDTH-1:0] TERM_COUNT = COUNT_WIDTH'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0]          LAST_IDX   = IW'(NUM_REQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] counter;
  logic [IW-1:0]          last_grant;
  logic [IW-1:0]          cur_idx;

  logic [IW-1:0]          base_idx;
  logic [IW-1:0]          win_idx;
  logic                   found;
  logic [15:0]            win_data;
  logic [3:0]             win_points;
  logic                   held;
  logic                   terminal;
  logic                   release_grant;
  logic                   start_grant;
  int                     cand;

  assign dbg_state = state;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // End-of-grant detection: abort on dropped request or completion at terminal count.
  always_comb begin
    held          = reqs[cur_idx];
    terminal      = (counter == TERM_COUNT);
    release_grant = (state == SHOW) && (!held || terminal);
    // In SHOW the search starts after the current holder, which wraps to itself last.
    base_idx      = (state == SHOW) ? cur_idx : last_grant;
  end

  // Round-robin search from base_idx+1 upward with wrap-around.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(base_idx) + 1 + k) % NUM_REQ;
      if (!found && reqs[cand]) begin
        found   = 1'b1;
        win_idx = IW'(cand);
      end
    end
    start_grant = found && ((state == IDLE) || release_grant);
  end

  // Select the winner's data and point mask for the snapshot.
  always_comb begin
    win_data   = '0;
    win_points = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(win_idx) == i) begin
        win_data   = reqData[16*i +: 16];
        win_points = reqPoints[4*i +: 4];
      end
    end
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      grant       <= '0;
      done        <= '0;
      data        <= IDLE_DATA;
      pointEnable <= '0;
      busy        <= 1'b0;
      counter     <= '0;
      last_grant  <= LAST_IDX;
      cur_idx     <= LAST_IDX;
    end else begin
      done <= '0;
      if (start_grant) begin
        state       <= SHOW;
        grant       <= onehot(win_idx);
        cur_idx     <= win_idx;
        data        <= win_data;
        pointEnable <= win_points;
        busy        <= 1'b1;
        counter     <= '0;
      end else if (release_grant) begin
        state       <= IDLE;
        grant       <= '0;
        data        <= IDLE_DATA;
        pointEnable <= '0;
        busy        <= 1'b0;
        counter     <= '0;
      end else if (state == SHOW) begin
        counter <= counter + 1'b1;
      end
      if (release_grant) begin
        last_grant <= cur_idx;
        if (held) begin
          done <= onehot(cur_idx);
        end
      end
    end
  end

endmodule
